pulse_catcher: RTL and testbench
================================

# pulse_catcher

Receiving end of the hold-until-acknowledged level handshake. A sender in another clock domain raises `IN` and holds it until it sees `ACK`. This block synchronizes `IN` into `CLK` and counts each low-to-high transition as one event. Events are queued in a saturating pending counter and drained through a `OUT_VALID`/`OUT_READY` handshake, one event per accepted transfer. It sits in the destination domain wherever a stretched request must become exactly one consumable event.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flops in the `IN` synchronizer; legal values 2..4.
- `CNT_WIDTH`, 4: pending-counter width; the queue holds up to 2^CNT_WIDTH-1 events.

Ports:
- `CLK`  in  1  single clock for all logic.
- `RST`  in  1  asynchronous, active-high reset.
- `IN`  in  1  held request level from the foreign domain; treated as asynchronous.
- `ACK`  out  1  reverse handshake; equals the synchronized `IN` level.
- `OUT_VALID`  out  1  high while pending != 0.
- `OUT_READY`  in  1  consumer accepts one event when high together with `OUT_VALID`.
- `PENDING`  out  CNT_WIDTH  current count of queued events.
- `OVERFLOW`  out  1  sticky; set when an event was lost because the queue was full.
- `CLR_OVF`  in  1  synchronous clear of `OVERFLOW`.

## Operation
- Synchronizer: `IN` -> SYNC_STAGES flops -> `s`. `ACK` = `s`.
- FSM, 2 states:
  - WAIT_HIGH: on `s`=1, record one event and go to WAIT_LOW.
  - WAIT_LOW: on `s`=0, go to WAIT_HIGH.
  - Exactly one event is recorded per high interval of `s`, however long it lasts.
- Pending counter, per edge (`pop` = `OUT_VALID` & `OUT_READY`):
  - event & !pop: +1.
  - pop & !event: -1.
  - event & pop: unchanged.
  - neither: unchanged.
- Full: pending = 2^CNT_WIDTH-1 with event & !pop -> pending unchanged, `OVERFLOW` set.
  - Event & pop while full -> unchanged, no overflow.
- Pending never wraps; pop is impossible at 0 because `OUT_VALID` is low.
- `OVERFLOW`:
  - `CLR_OVF` clears it.
  - If a new overflow coincides with `CLR_OVF`, set wins.
- Reset (asynchronous, any time): sync flops=0, state=WAIT_HIGH, pending=0, `OVERFLOW`=0.
  - Outputs after reset: `ACK`=0, `OUT_VALID`=0, `PENDING`=0.
  - Reset mid-queue discards all pending events.
  - If `IN` is still high at reset release, one new event is recorded after synchronization.
- The sender must keep `IN` low until `ACK` is seen low before the next request. A glitch shorter than one `CLK` period may be missed; no further filtering is done.

## Timing
- Edge numbering: edge 1 is the first `CLK` edge that samples `IN`=1.
- `ACK` rises after edge SYNC_STAGES.
- The event is recorded on edge SYNC_STAGES+1: `PENDING` increments and `OUT_VALID` rises after that edge. Latency is 3 edges for the default.
- `OUT_VALID` is combinational from the pending register: no extra cycle, no dependence on `OUT_READY`.
- A pop at edge k takes effect after edge k; back-to-back pops drain one event per cycle.
- `ACK` falls SYNC_STAGES edges after `IN` is first sampled low.
- `OVERFLOW` is registered; it becomes visible after the edge of the lost event.

## Structure
- Shared package `pulse_catcher_pkg`:
  - state encoding constants `ST_WAIT_HIGH`=1'b0 and `ST_WAIT_LOW`=1'b1.
  - localparam helper for the full value, (1<<CNT_WIDTH)-1.
- One sub-module `sync_chain`:
  - parameterized by SYNC_STAGES.
  - asynchronous active-high reset to 0.
  - reusable by other CDC blocks.
- The FSM, counter and overflow logic stay in `pulse_catcher`.

## Test plan
- Reset release, `IN`=0 -> `ACK`=0, `OUT_VALID`=0, `PENDING`=0, `OVERFLOW`=0. Then raise `IN` for 10 cycles with `OUT_READY`=0:
  - `ACK`=1 after edge 2.
  - `PENDING`=1 after edge 3 and stays 1 (one event only).
- Three separate requests, each held 6 cycles with 4 low cycles between, `OUT_READY`=0 -> `PENDING`=3. Then `OUT_READY`=1 for 3 cycles -> `PENDING` 2,1,0; `OUT_VALID` low after the third pop.
- Event and pop on the same edge with `PENDING`=2 -> `PENDING` stays 2.
- CNT_WIDTH=2, four requests with no pops:
  - `PENDING` saturates at 3 and `OVERFLOW`=1.
  - Pulse `CLR_OVF` -> `OVERFLOW`=0, `PENDING` still 3.
- Assert `RST` for 1 cycle mid-operation with `PENDING`=2 and `IN`=1:
  - Immediate (asynchronous) `PENDING`=0, `ACK`=0.
  - After release, `PENDING`=1 after edge 3.
- SYNC_STAGES=3 -> `ACK` after edge 3, event after edge 4. A 1-cycle `IN` pulse aligned to an edge is counted exactly once.

Source files
------------

// File: rtl/pulse_catcher_pkg.sv
// Shared types and helpers for the pulse_catcher level-handshake receiver.
package pulse_catcher_pkg;

  typedef enum logic {
    ST_WAIT_HIGH = 1'b0,
    ST_WAIT_LOW  = 1'b1
  } state_t;

  // Largest value a pending counter of the given width can hold.
  function automatic int unsigned full_count(input int unsigned cnt_width);
    return (32'd1 << cnt_width) - 32'd1;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for a single asynchronous level; resets to 0.
module sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES:0] sync_reg;

  assign sync_reg[0] = d;

  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        sync_reg[gi+1] <= 1'b0;
      end else begin
        sync_reg[gi+1] <= sync_reg[gi];
      end
    end
  end

  assign q = sync_reg[SYNC_STAGES];

endmodule

// File: rtl/pulse_catcher.sv
// Turns each high interval of a synchronized request level into exactly one
// queued event, drained one per accepted OUT_VALID/OUT_READY transfer.
module pulse_catcher
  import pulse_catcher_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 IN,
  output logic                 ACK,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [CNT_WIDTH-1:0] PENDING,
  output logic                 OVERFLOW,
  input  logic                 CLR_OVF
);

  localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(full_count(CNT_WIDTH));

  logic                 in_sync;
  state_t               state_reg, state_next;
  logic                 event_rec;
  logic                 pop;
  logic [CNT_WIDTH-1:0] pending_reg, pending_next;
  logic                 overflow_reg, overflow_next;

  sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .CLK(CLK),
    .RST(RST),
    .d  (IN),
    .q  (in_sync)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg    <= ST_WAIT_HIGH;
      pending_reg  <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pending_reg  <= pending_next;
      overflow_reg <= overflow_next;
    end
  end

  // One event on entry to each high interval; re-arm only once s drops.
  always_comb begin
    state_next = state_reg;
    event_rec  = 1'b0;
    unique case (state_reg)
      ST_WAIT_HIGH: begin
        if (in_sync) begin
          event_rec  = 1'b1;
          state_next = ST_WAIT_LOW;
        end
      end
      ST_WAIT_LOW: begin
        if (!in_sync) begin
          state_next = ST_WAIT_HIGH;
        end
      end
      default: state_next = ST_WAIT_HIGH;
    endcase
  end

  assign pop = OUT_VALID & OUT_READY;

  // Clear is applied first so a coinciding overflow still sets the flag.
  always_comb begin
    pending_next  = pending_reg;
    overflow_next = overflow_reg;
    if (CLR_OVF) begin
      overflow_next = 1'b0;
    end
    if (event_rec && !pop) begin
      if (pending_reg == FULL) begin
        overflow_next = 1'b1;
      end else begin
        pending_next = pending_reg + 1'b1;
      end
    end else if (pop && !event_rec) begin
      pending_next = pending_reg - 1'b1;
    end
  end

  assign ACK       = in_sync;
  assign OUT_VALID = |pending_reg;
  assign PENDING   = pending_reg;
  assign OVERFLOW  = overflow_reg;

endmodule

// File: tb/tb_pulse_catcher.sv
// Drives three pulse_catcher configurations with shared stimulus and checks each
// against a delay-line/queue reference model every cycle.
module tb_pulse_catcher;

  logic CLK = 1'b0;
  logic RST, IN, OUT_READY, CLR_OVF;

  logic       ack0, ack1, ack2;
  logic       valid0, valid1, valid2;
  logic       ovf0, ovf1, ovf2;
  logic [3:0] pend0, pend2;
  logic [1:0] pend1;

  int n_checks;
  int n_errors;

  // Reference model state, one slot per instance.
  int m_hist[3];
  int m_seen[3];
  int m_pend[3];
  int m_ovf[3];

  always #5 CLK = ~CLK;

  pulse_catcher #(.SYNC_STAGES(2), .CNT_WIDTH(4)) u_dut0 (
    .CLK(CLK), .RST(RST), .IN(IN), .ACK(ack0), .OUT_VALID(valid0),
    .OUT_READY(OUT_READY), .PENDING(pend0), .OVERFLOW(ovf0), .CLR_OVF(CLR_OVF)
  );

  pulse_catcher #(.SYNC_STAGES(2), .CNT_WIDTH(2)) u_dut1 (
    .CLK(CLK), .RST(RST), .IN(IN), .ACK(ack1), .OUT_VALID(valid1),
    .OUT_READY(OUT_READY), .PENDING(pend1), .OVERFLOW(ovf1), .CLR_OVF(CLR_OVF)
  );

  pulse_catcher #(.SYNC_STAGES(3), .CNT_WIDTH(4)) u_dut2 (
    .CLK(CLK), .RST(RST), .IN(IN), .ACK(ack2), .OUT_VALID(valid2),
    .OUT_READY(OUT_READY), .PENDING(pend2), .OVERFLOW(ovf2), .CLR_OVF(CLR_OVF)
  );

  function automatic int stages(input int i);
    return (i == 2) ? 3 : 2;
  endfunction

  function automatic int width(input int i);
    return (i == 1) ? 2 : 4;
  endfunction

  function automatic int dut_ack(input int i);
    case (i)
      0: return int'(ack0);
      1: return int'(ack1);
      default: return int'(ack2);
    endcase
  endfunction

  function automatic int dut_valid(input int i);
    case (i)
      0: return int'(valid0);
      1: return int'(valid1);
      default: return int'(valid2);
    endcase
  endfunction

  function automatic int dut_pend(input int i);
    case (i)
      0: return int'(pend0);
      1: return int'(pend1);
      default: return int'(pend2);
    endcase
  endfunction

  function automatic int dut_ovf(input int i);
    case (i)
      0: return int'(ovf0);
      1: return int'(ovf1);
      default: return int'(ovf2);
    endcase
  endfunction

  task automatic check_value(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_hist[i] = 0;
      m_seen[i] = 0;
      m_pend[i] = 0;
      m_ovf[i]  = 0;
    end
  endtask

  // Synchronized level = IN delayed by SYNC_STAGES samples; an event is a
  // rising edge of that level; the queue saturates at 2^W-1.
  task automatic model_step();
    int s_now, ev, pop, full;
    if (RST) begin
      model_reset();
    end else begin
      for (int i = 0; i < 3; i++) begin
        s_now = (m_hist[i] >> (stages(i) - 1)) & 1;
        ev    = (s_now == 1 && m_seen[i] == 0) ? 1 : 0;
        m_seen[i] = s_now;
        pop   = (m_pend[i] != 0 && OUT_READY) ? 1 : 0;
        full  = (1 << width(i)) - 1;
        if (CLR_OVF) m_ovf[i] = 0;
        if (ev == 1 && pop == 0) begin
          if (m_pend[i] == full) m_ovf[i] = 1;
          else m_pend[i] = m_pend[i] + 1;
        end else if (pop == 1 && ev == 0) begin
          m_pend[i] = m_pend[i] - 1;
        end
        m_hist[i] = ((m_hist[i] << 1) | int'(IN)) & 32'hFF;
      end
    end
  endtask

  task automatic check_model();
    for (int i = 0; i < 3; i++) begin
      check_value($sformatf("ack%0d", i),   dut_ack(i),   (m_hist[i] >> (stages(i) - 1)) & 1);
      check_value($sformatf("valid%0d", i), dut_valid(i), (m_pend[i] != 0) ? 1 : 0);
      check_value($sformatf("pend%0d", i),  dut_pend(i),  m_pend[i]);
      check_value($sformatf("ovf%0d", i),   dut_ovf(i),   m_ovf[i]);
    end
  endtask

  // Advance one clock: model follows the edge, outputs checked on the falling edge.
  task automatic cycle();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    check_model();
  endtask

  // Called at a falling edge; reset must take effect without a clock edge.
  task automatic async_reset();
    RST = 1'b1;
    #1;
    model_reset();
    check_value("rst_async_pend0", dut_pend(0), 0);
    check_value("rst_async_ack0", dut_ack(0), 0);
    check_model();
    cycle();
    RST = 1'b0;
  endtask

  task automatic request(input int high_cycles, input int low_cycles);
    IN = 1'b1;
    repeat (high_cycles) cycle();
    IN = 1'b0;
    repeat (low_cycles) cycle();
  endtask

  initial begin
    int hold_left;
    int ready_pct;
    n_checks  = 0;
    n_errors  = 0;
    RST       = 1'b1;
    IN        = 1'b0;
    OUT_READY = 1'b0;
    CLR_OVF   = 1'b0;
    model_reset();
    repeat (2) cycle();
    check_value("reset_ack", dut_ack(0), 0);
    check_value("reset_valid", dut_valid(0), 0);
    check_value("reset_pend", dut_pend(0), 0);
    check_value("reset_ovf", dut_ovf(0), 0);
    RST = 1'b0;
    cycle();

    // Long request: one event only, latency per SYNC_STAGES.
    IN = 1'b1;
    cycle();
    check_value("long_ack_e1", dut_ack(0), 0);
    cycle();
    check_value("long_ack_e2", dut_ack(0), 1);
    check_value("long_pend_e2", dut_pend(0), 0);
    cycle();
    check_value("long_pend_e3", dut_pend(0), 1);
    check_value("long_valid_e3", dut_valid(0), 1);
    check_value("s3_ack_e3", dut_ack(2), 1);
    check_value("s3_pend_e3", dut_pend(2), 0);
    cycle();
    check_value("s3_pend_e4", dut_pend(2), 1);
    repeat (6) cycle();
    check_value("long_pend_hold", dut_pend(0), 1);
    IN = 1'b0;
    repeat (6) cycle();

    // Three requests, then drain back to back.
    async_reset();
    repeat (3) request(6, 4);
    check_value("three_pend0", dut_pend(0), 3);
    check_value("three_pend1", dut_pend(1), 3);
    check_value("three_ovf1", dut_ovf(1), 0);
    OUT_READY = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      cycle();
      check_value($sformatf("drain_pop%0d", k), dut_pend(0), 3 - k);
    end
    OUT_READY = 1'b0;
    check_value("drain_valid", dut_valid(0), 0);

    // Event and pop on the same edge.
    async_reset();
    repeat (2) request(6, 4);
    check_value("evpop_pre", dut_pend(0), 2);
    IN = 1'b1;
    repeat (2) cycle();
    OUT_READY = 1'b1;
    cycle();
    OUT_READY = 1'b0;
    check_value("evpop_pend0", dut_pend(0), 2);
    repeat (3) cycle();
    IN = 1'b0;
    repeat (4) cycle();

    // Saturation on the narrow counter, then clear the sticky flag.
    async_reset();
    repeat (4) request(6, 4);
    check_value("sat_pend1", dut_pend(1), 3);
    check_value("sat_ovf1", dut_ovf(1), 1);
    check_value("sat_pend0", dut_pend(0), 4);
    check_value("sat_ovf0", dut_ovf(0), 0);
    CLR_OVF = 1'b1;
    cycle();
    CLR_OVF = 1'b0;
    check_value("clr_ovf1", dut_ovf(1), 0);
    check_value("clr_pend1", dut_pend(1), 3);

    // Overflow coinciding with clear: set wins.
    IN = 1'b1;
    repeat (2) cycle();
    CLR_OVF = 1'b1;
    cycle();
    CLR_OVF = 1'b0;
    check_value("setwins_ovf1", dut_ovf(1), 1);
    IN = 1'b0;
    repeat (4) cycle();

    // Reset mid-queue with IN held high.
    async_reset();
    repeat (2) request(6, 4);
    IN = 1'b1;
    cycle();
    check_value("midrst_pre", dut_pend(0), 2);
    async_reset();
    repeat (2) cycle();
    check_value("midrst_e2", dut_pend(0), 0);
    cycle();
    check_value("midrst_e3", dut_pend(0), 1);
    IN = 1'b0;
    repeat (5) cycle();

    // Single-cycle pulse counted once.
    async_reset();
    IN = 1'b1;
    cycle();
    IN = 1'b0;
    repeat (6) cycle();
    check_value("pulse_pend2", dut_pend(2), 1);
    check_value("pulse_pend0", dut_pend(0), 1);

    // Randomized traffic against the model.
    async_reset();
    hold_left = 0;
    ready_pct = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) ready_pct = $urandom_range(0, 100);
      if (hold_left == 0) begin
        IN = ~IN;
        hold_left = $urandom_range(1, 8);
      end
      hold_left--;
      OUT_READY = ($urandom_range(0, 99) < ready_pct) ? 1'b1 : 1'b0;
      CLR_OVF   = ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0;
      if ($urandom_range(0, 499) == 0) begin
        async_reset();
      end else begin
        cycle();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
